// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register, write-back data select, register file write/read ports and retire counter.
// WB outputs follow MEM inputs by one cycle; stall holds the stage, flush loads a bubble.
module mem_wb_writeback #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              mem_RegWrite,
  input  logic [1:0]        mem_MemtoReg,
  input  logic [DATA_W-1:0] mem_ALUResult,
  input  logic [DATA_W-1:0] mem_ReadData,
  input  logic [DATA_W-1:0] mem_PCPlus4,
  input  logic [ADDR_W-1:0] mem_WriteRegister,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] WriteData,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic              RegWrite,
  output logic [CNT_W-1:0]  retired_count
);

  localparam int NREGS = 1 << ADDR_W;

  logic              r_wb_valid;
  logic              r_wb_regwrite;
  logic [1:0]        r_wb_memtoreg;
  logic [DATA_W-1:0] r_wb_aluresult;
  logic [DATA_W-1:0] r_wb_readdata;
  logic [DATA_W-1:0] r_wb_pcplus4;
  logic [ADDR_W-1:0] r_wb_wreg;
  logic [DATA_W-1:0] r_regs [NREGS];
  logic [CNT_W-1:0]  r_retired;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_rf_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid     <= 1'b0;
      r_wb_regwrite  <= 1'b0;
      r_wb_memtoreg  <= 2'b00;
      r_wb_aluresult <= '0;
      r_wb_readdata  <= '0;
      r_wb_pcplus4   <= '0;
      r_wb_wreg      <= '0;
    end else if (flush) begin
      r_wb_valid     <= 1'b0;
      r_wb_regwrite  <= 1'b0;
      r_wb_memtoreg  <= 2'b00;
      r_wb_aluresult <= '0;
      r_wb_readdata  <= '0;
      r_wb_pcplus4   <= '0;
      r_wb_wreg      <= '0;
    end else if (!stall) begin
      r_wb_valid     <= mem_valid;
      r_wb_regwrite  <= mem_RegWrite;
      r_wb_memtoreg  <= mem_MemtoReg;
      r_wb_aluresult <= mem_ALUResult;
      r_wb_readdata  <= mem_ReadData;
      r_wb_pcplus4   <= mem_PCPlus4;
      r_wb_wreg      <= mem_WriteRegister;
    end
  end

  // MemtoReg=11 is treated as an ALU write-back.
  always_comb begin
    w_sel_data = r_wb_aluresult;
    case (r_wb_memtoreg)
      2'b01:   w_sel_data = r_wb_readdata;
      2'b10:   w_sel_data = r_wb_pcplus4;
      default: w_sel_data = r_wb_aluresult;
    endcase
  end

  assign RegWrite      = r_wb_valid & r_wb_regwrite;
  assign WriteRegister = r_wb_valid ? r_wb_wreg : '0;
  assign WriteData     = r_wb_valid ? w_sel_data : '0;
  assign w_rf_we       = RegWrite && (WriteRegister != '0);

  // The write uses the current WB outputs, so a flush/stall on the same edge cannot cancel it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_rf_we) begin
      r_regs[WriteRegister] <= WriteData;
    end
  end

  // Raw reads; same-cycle bypass belongs to the forwarding unit in ID.
  assign ReadData1 = (rs == '0) ? '0 : r_regs[rs];
  assign ReadData2 = (rt == '0) ? '0 : r_regs[rt];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (r_wb_valid && !stall) begin
      r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign retired_count = r_retired;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Bench for mem_wb_writeback: directed scenarios plus randomized traffic against a behavioural model.
module tb_mem_wb_writeback;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n, stall, flush, mem_valid, mem_RegWrite;
  logic [1:0]    mem_MemtoReg;
  logic [DW-1:0] mem_ALUResult, mem_ReadData, mem_PCPlus4;
  logic [AW-1:0] mem_WriteRegister, rs, rt;
  logic [DW-1:0] ReadData1, ReadData2, WriteData;
  logic [AW-1:0] WriteRegister;
  logic          RegWrite;
  logic [CW-1:0] retired_count;

  always #5 clk = ~clk;

  mem_wb_writeback #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_RegWrite(mem_RegWrite), .mem_MemtoReg(mem_MemtoReg),
    .mem_ALUResult(mem_ALUResult), .mem_ReadData(mem_ReadData), .mem_PCPlus4(mem_PCPlus4),
    .mem_WriteRegister(mem_WriteRegister), .rs(rs), .rt(rt),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .WriteData(WriteData),
    .WriteRegister(WriteRegister), .RegWrite(RegWrite), .retired_count(retired_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: the instruction sitting in WB, the architectural registers, the retire count.
  logic          m_valid, m_rw;
  logic [1:0]    m_mtr;
  logic [DW-1:0] m_alu, m_rd, m_pc4;
  logic [AW-1:0] m_wr;
  logic [DW-1:0] m_regs [32];
  logic [CW-1:0] m_cnt;

  function automatic logic [DW-1:0] exp_wdata();
    if (!m_valid) return '0;
    if (m_mtr == 2'b01) return m_rd;
    if (m_mtr == 2'b10) return m_pc4;
    return m_alu;
  endfunction

  function automatic logic exp_rw();
    return m_valid && m_rw;
  endfunction

  function automatic logic [AW-1:0] exp_wreg();
    return m_valid ? m_wr : '0;
  endfunction

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    return (a == 0) ? '0 : m_regs[a];
  endfunction

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_mtr = 0; m_alu = 0; m_rd = 0; m_pc4 = 0; m_wr = 0; m_cnt = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
  endtask

  task automatic set_mem(input logic v, input logic w, input logic [1:0] mtr, input logic [DW-1:0] alu,
                         input logic [DW-1:0] rd, input logic [DW-1:0] pc4, input logic [AW-1:0] wr);
    mem_valid = v; mem_RegWrite = w; mem_MemtoReg = mtr;
    mem_ALUResult = alu; mem_ReadData = rd; mem_PCPlus4 = pc4; mem_WriteRegister = wr;
  endtask

  task automatic bubble();
    set_mem(0, 0, 2'b00, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)));
  endtask

  // One rising edge: update the model from the pre-edge state, then settle 1 time unit past the edge.
  task automatic step();
    @(posedge clk);
    if (exp_rw() && exp_wreg() != 0) m_regs[exp_wreg()] = exp_wdata();
    if (m_valid && !stall) m_cnt = m_cnt + 8'd1;
    if (flush) begin
      m_valid = 0; m_rw = 0;
    end else if (!stall) begin
      m_valid = mem_valid; m_rw = mem_RegWrite; m_mtr = mem_MemtoReg;
      m_alu = mem_ALUResult; m_rd = mem_ReadData; m_pc4 = mem_PCPlus4; m_wr = mem_WriteRegister;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; stall = 0; flush = 0; rs = 5; rt = 0;
    set_mem(1, 1, 2'b00, 32'h55, 32'h66, 32'h77, 5'd3);
    model_reset();
    #12;
    n_checks++; if (ReadData1 !== 32'h0) begin n_fail++; $display("FAIL reset_rd1: got %h want 0", ReadData1); end
    n_checks++; if (ReadData2 !== 32'h0) begin n_fail++; $display("FAIL reset_rd2: got %h want 0", ReadData2); end
    n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite: got %b want 0", RegWrite); end
    n_checks++; if (retired_count !== 8'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", retired_count); end
    n_checks++; if (WriteData !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", WriteData); end
    @(negedge clk);
    rst_n = 1;
    bubble();
    step();
  endtask

  task automatic test_alu_write();
    set_mem(1, 1, 2'b00, 32'h1234, $urandom, $urandom, 5'd5);
    step();
    bubble(); rs = 5; #1;
    n_checks++; if (WriteData !== 32'h1234) begin n_fail++; $display("FAIL alu_wdata: got %h want 1234", WriteData); end
    n_checks++; if (RegWrite !== 1'b1) begin n_fail++; $display("FAIL alu_regwrite: got %b want 1", RegWrite); end
    n_checks++; if (WriteRegister !== 5'd5) begin n_fail++; $display("FAIL alu_wreg: got %0d want 5", WriteRegister); end
    n_checks++; if (ReadData1 !== 32'h0) begin n_fail++; $display("FAIL alu_pre_read: got %h want 0", ReadData1); end
    step();
    n_checks++; if (ReadData1 !== 32'h1234) begin n_fail++; $display("FAIL alu_post_read: got %h want 1234", ReadData1); end
    n_checks++; if (retired_count !== 8'd1) begin n_fail++; $display("FAIL alu_count: got %0d want 1", retired_count); end
  endtask

  task automatic test_load_link();
    set_mem(1, 1, 2'b01, $urandom, 32'hDEADBEEF, $urandom, 5'd7);
    step();
    set_mem(1, 1, 2'b10, $urandom, $urandom, 32'h40, 5'd31); #1;
    n_checks++; if (WriteData !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_wdata: got %h want deadbeef", WriteData); end
    step();
    set_mem(1, 1, 2'b00, 32'hFFFF, $urandom, $urandom, 5'd0); #1;
    n_checks++; if (WriteData !== 32'h40) begin n_fail++; $display("FAIL link_wdata: got %h want 40", WriteData); end
    n_checks++; if (WriteRegister !== 5'd31) begin n_fail++; $display("FAIL link_wreg: got %0d want 31", WriteRegister); end
    step();
    bubble(); #1;
    n_checks++; if (WriteData !== 32'hFFFF) begin n_fail++; $display("FAIL r0_wdata: got %h want ffff", WriteData); end
    step();
    rs = 7; rt = 31; #1;
    n_checks++; if (ReadData1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_r7: got %h want deadbeef", ReadData1); end
    n_checks++; if (ReadData2 !== 32'h40) begin n_fail++; $display("FAIL link_r31: got %h want 40", ReadData2); end
    rs = 0; #1;
    n_checks++; if (ReadData1 !== 32'h0) begin n_fail++; $display("FAIL r0_read: got %h want 0", ReadData1); end
  endtask

  task automatic test_stall_flush();
    logic [CW-1:0] cnt0;
    set_mem(1, 1, 2'b00, 32'hA5A5, $urandom, $urandom, 5'd12);
    step();
    cnt0 = m_cnt;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_mem(1, 1, 2'b10, $urandom, $urandom, $urandom, 5'd13); #1;
      n_checks++; if (WriteData !== 32'hA5A5) begin n_fail++; $display("FAIL stall_wdata[%0d]: got %h want a5a5", i, WriteData); end
      n_checks++; if (WriteRegister !== 5'd12) begin n_fail++; $display("FAIL stall_wreg[%0d]: got %0d want 12", i, WriteRegister); end
      n_checks++; if (retired_count !== cnt0) begin n_fail++; $display("FAIL stall_count[%0d]: got %0d want %0d", i, retired_count, cnt0); end
      step();
    end
    stall = 0; bubble();
    step();
    n_checks++; if (retired_count !== cnt0 + 8'd1) begin n_fail++; $display("FAIL stall_retire_once: got %0d want %0d", retired_count, cnt0 + 8'd1); end
    rs = 12; #1;
    n_checks++; if (ReadData1 !== 32'hA5A5) begin n_fail++; $display("FAIL stall_r12: got %h want a5a5", ReadData1); end
    set_mem(1, 1, 2'b01, $urandom, 32'h7777, $urandom, 5'd14);
    step();
    stall = 1; flush = 1;
    step();
    stall = 0; flush = 0; bubble(); #1;
    n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL flush_regwrite: got %b want 0", RegWrite); end
    n_checks++; if (WriteData !== 32'h0) begin n_fail++; $display("FAIL flush_wdata: got %h want 0", WriteData); end
    rs = 14; #1;
    n_checks++; if (ReadData1 !== 32'h7777) begin n_fail++; $display("FAIL flush_keeps_write: got %h want 7777", ReadData1); end
    n_checks++; if (retired_count !== cnt0 + 8'd1) begin n_fail++; $display("FAIL flush_stall_count: got %0d want %0d", retired_count, cnt0 + 8'd1); end
  endtask

  task automatic test_same_cycle();
    logic [DW-1:0] old_v, new_v;
    old_v = $urandom; new_v = ~old_v;
    set_mem(1, 1, 2'b00, old_v, $urandom, $urandom, 5'd9);
    step();
    bubble();
    step();
    set_mem(1, 1, 2'b00, new_v, $urandom, $urandom, 5'd9);
    step();
    bubble(); rs = 9; #1;
    n_checks++; if (ReadData1 !== old_v) begin n_fail++; $display("FAIL bypass_old: got %h want %h", ReadData1, old_v); end
    n_checks++; if (WriteData !== new_v) begin n_fail++; $display("FAIL bypass_wdata: got %h want %h", WriteData, new_v); end
    step();
    n_checks++; if (ReadData1 !== new_v) begin n_fail++; $display("FAIL bypass_new: got %h want %h", ReadData1, new_v); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      set_mem($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
              $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)));
      rs = 5'($urandom_range(0, 31)); rt = 5'($urandom_range(0, 31)); #1;
      n_checks++; if (RegWrite !== exp_rw()) begin n_fail++; $display("FAIL rnd_regwrite c%0d: got %b want %b", c, RegWrite, exp_rw()); end
      n_checks++; if (WriteRegister !== exp_wreg()) begin n_fail++; $display("FAIL rnd_wreg c%0d: got %0d want %0d", c, WriteRegister, exp_wreg()); end
      n_checks++; if (WriteData !== exp_wdata()) begin n_fail++; $display("FAIL rnd_wdata c%0d: got %h want %h", c, WriteData, exp_wdata()); end
      n_checks++; if (ReadData1 !== exp_read(rs)) begin n_fail++; $display("FAIL rnd_rd1 c%0d: got %h want %h", c, ReadData1, exp_read(rs)); end
      n_checks++; if (ReadData2 !== exp_read(rt)) begin n_fail++; $display("FAIL rnd_rd2 c%0d: got %h want %h", c, ReadData2, exp_read(rt)); end
      n_checks++; if (retired_count !== m_cnt) begin n_fail++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, retired_count, m_cnt); end
      step();
    end
    stall = 0; flush = 0;
  endtask

  task automatic test_wrap();
    int guard;
    guard = 0;
    set_mem(1, 0, 2'b00, $urandom, $urandom, $urandom, 5'd1);
    while (m_cnt != 8'hFF && guard < 600) begin
      step();
      guard++;
    end
    n_checks++; if (retired_count !== 8'hFF) begin n_fail++; $display("FAIL wrap_max: got %0d want 255 (steps %0d)", retired_count, guard); end
    step();
    n_checks++; if (retired_count !== 8'h00) begin n_fail++; $display("FAIL wrap_zero: got %0d want 0", retired_count); end
    bubble();
    step();
  endtask

  task automatic test_reset_mid();
    set_mem(1, 1, 2'b00, 32'hCAFE, $urandom, $urandom, 5'd3);
    step();
    #2;
    rst_n = 0;
    model_reset();
    #1;
    n_checks++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL midrst_regwrite: got %b want 0", RegWrite); end
    n_checks++; if (WriteData !== 32'h0) begin n_fail++; $display("FAIL midrst_wdata: got %h want 0", WriteData); end
    n_checks++; if (WriteRegister !== 5'd0) begin n_fail++; $display("FAIL midrst_wreg: got %0d want 0", WriteRegister); end
    n_checks++; if (retired_count !== 8'd0) begin n_fail++; $display("FAIL midrst_count: got %0d want 0", retired_count); end
    for (int i = 0; i < 32; i++) begin
      rs = 5'(i); #1;
      n_checks++; if (ReadData1 !== 32'h0) begin n_fail++; $display("FAIL midrst_reg[%0d]: got %h want 0", i, ReadData1); end
    end
    @(negedge clk);
    rst_n = 1; bubble();
    rs = 3; #1;
    n_checks++; if (ReadData1 !== 32'h0) begin n_fail++; $display("FAIL midrst_no_write: got %h want 0", ReadData1); end
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_load_link();
    test_stall_flush();
    test_same_cycle();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
